// File: rtl/cell_expander_if.sv
// Cell expander bus: cell push side, pixel request side and status.
// The master drives cells and requests; the slave (the expander) returns
// pixels, the FIFO level and the sticky error flags.
interface cell_expander_if #(
   parameter int DEPTH = 4
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             valid_cell;
   logic [23:0]      cell_RGB;
   logic             sof;
   logic             req_pixel;
   logic             valid_RGB_Data;
   logic [23:0]      RGB_Data;
   logic [LVL_W-1:0] fifo_level;
   logic             underflow;
   logic             overflow;

   modport master (
      output valid_cell, cell_RGB, sof, req_pixel,
      input  valid_RGB_Data, RGB_Data, fifo_level, underflow, overflow
   );

   modport slave (
      input  valid_cell, cell_RGB, sof, req_pixel,
      output valid_RGB_Data, RGB_Data, fifo_level, underflow, overflow
   );
endinterface

// File: rtl/cell_expander.sv
// Cell expander: buffers one RGB value per cell in a small FIFO and replays
// the head value for CELL_LEN requested pixels before popping it, rebuilding
// a full-rate pixel stream. All logic runs on the falling edge of clkn.
module cell_expander #(
   parameter int CELL_LEN = 24,
   parameter int DEPTH    = 4
) (
   input logic            clkn,
   input logic            resetn,
   cell_expander_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LP_LVL_FULL = LVL_W'(DEPTH);
   localparam logic [7:0]       LP_REP_LAST = 8'(CELL_LEN - 1);

   logic [23:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [7:0]       r_rep_cnt;
   logic             r_underflow;
   logic             r_overflow;
   logic             r_vld_p1;
   logic [23:0]      r_data_p1;

   logic             w_has_cell;
   logic             w_emit;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [PTR_W-1:0] w_wr_addr;
   logic [LVL_W-1:0] w_level_nxt;

   // A flush takes priority over replay: it suppresses emission and the
   // underflow check, and a same-cycle push lands in the emptied FIFO.
   assign w_has_cell = (r_level != '0);
   assign w_emit     = bus.req_pixel & w_has_cell & ~bus.sof;
   assign w_pop      = w_emit & (r_rep_cnt == LP_REP_LAST);
   assign w_push     = bus.valid_cell & (bus.sof | (r_level != LP_LVL_FULL) | w_pop);
   assign w_drop     = bus.valid_cell & ~w_push;
   assign w_wr_addr  = bus.sof ? '0 : r_wr_ptr;

   // Next FIFO level: flush restarts from the same-cycle push, otherwise
   // push and pop cancel when both happen.
   always_comb begin
      w_level_nxt = r_level;
      if (bus.sof) begin
         w_level_nxt = LVL_W'(bus.valid_cell);
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
         endcase
      end
   end

   // Cell storage; contents need no reset because level gates every read.
   always_ff @(negedge clkn) begin
      if (w_push) begin
         r_mem[w_wr_addr] <= bus.cell_RGB;
      end
   end

   // FIFO pointers, level, repeat counter and sticky error flags.
   always_ff @(negedge clkn or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_rep_cnt   <= '0;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_level <= w_level_nxt;
         if (bus.sof) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= PTR_W'(bus.valid_cell);
            r_rep_cnt <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
               r_rep_cnt <= '0;
            end else if (w_emit) begin
               r_rep_cnt <= r_rep_cnt + 8'd1;
            end
         end
         if (bus.req_pixel && !w_has_cell && !bus.sof) begin
            r_underflow <= 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ---- stage p1: registered pixel output, zero whenever not valid ----
   always_ff @(negedge clkn or negedge resetn) begin
      if (!resetn) begin
         r_vld_p1  <= 1'b0;
         r_data_p1 <= '0;
      end else begin
         r_vld_p1  <= w_emit;
         r_data_p1 <= w_emit ? r_mem[r_rd_ptr] : '0;
      end
   end

   assign bus.valid_RGB_Data = r_vld_p1;
   assign bus.RGB_Data       = r_data_p1;
   assign bus.fifo_level     = r_level;
   assign bus.underflow      = r_underflow;
   assign bus.overflow       = r_overflow;
endmodule

// File: tb/tb_cell_expander.sv
// Scoreboard bench for cell_expander: the stimulus process queues the pixel
// value each request should produce; the monitor pops and compares whenever
// the DUT presents a valid pixel. Status outputs are checked inline.
module tb_cell_expander;
   localparam int CELL_LEN = 24;
   localparam int DEPTH    = 4;

   logic clkn;
   logic resetn;

   cell_expander_if #(.DEPTH(DEPTH)) bus ();

   cell_expander #(.CELL_LEN(CELL_LEN), .DEPTH(DEPTH)) dut (
      .clkn   (clkn),
      .resetn (resetn),
      .bus    (bus)
   );

   logic [23:0] exp_q [$];
   int n_chk  = 0;
   int n_pass = 0;

   initial begin
      clkn = 1'b0;
      forever #5 clkn = ~clkn;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_st(input string name, input int lvl, input logic uf, input logic of);
      chk({name, ".level"},     32'(bus.fifo_level), 32'(lvl));
      chk({name, ".underflow"}, 32'(bus.underflow),  32'(uf));
      chk({name, ".overflow"},  32'(bus.overflow),   32'(of));
   endtask

   task automatic chk_out_zero(input string name);
      chk({name, ".valid"}, 32'(bus.valid_RGB_Data), 32'd0);
      chk({name, ".data"},  32'(bus.RGB_Data),       32'd0);
   endtask

   // Inputs are driven just after the rising edge, the DUT samples them on
   // the falling edge, and the task returns at the next rising edge.
   task automatic step(input logic req, input logic vc, input logic [23:0] rgb, input logic sf);
      bus.req_pixel  = req;
      bus.valid_cell = vc;
      bus.cell_RGB   = rgb;
      bus.sof        = sf;
      @(posedge clkn);
   endtask

   task automatic push(input logic [23:0] rgb);
      step(1'b0, 1'b1, rgb, 1'b0);
   endtask

   task automatic req_exp(input logic [23:0] e);
      exp_q.push_back(e);
      step(1'b1, 1'b0, 24'h0, 1'b0);
   endtask

   task automatic req_none();
      step(1'b1, 1'b0, 24'h0, 1'b0);
   endtask

   // Monitor: compare every valid pixel against the scoreboard head.
   initial begin
      logic [23:0] e;
      forever begin
         @(posedge clkn);
         if (bus.valid_RGB_Data) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_pixel: got 0x%0h, expected no pixel", bus.RGB_Data);
            end else begin
               e = exp_q.pop_front();
               chk("pixel", 32'(bus.RGB_Data), 32'(e));
            end
         end else begin
            chk("idle_data", 32'(bus.RGB_Data), 32'd0);
         end
      end
   end

   initial begin
      logic [23:0] v;
      resetn         = 1'b1;
      bus.valid_cell = 1'b0;
      bus.cell_RGB   = 24'h0;
      bus.sof        = 1'b0;
      bus.req_pixel  = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk_out_zero("reset");
      chk_st("reset", 0, 1'b0, 1'b0);
      repeat (2) @(posedge clkn);
      resetn = 1'b1;

      // Single cell replayed CELL_LEN times, then an underflowing request
      push(24'h123456);
      chk_st("t1.push", 1, 1'b0, 1'b0);
      for (int i = 0; i < CELL_LEN; i++) begin
         req_exp(24'h123456);
         if (i == CELL_LEN - 2) chk_st("t1.req23", 1, 1'b0, 1'b0);
         if (i == CELL_LEN - 1) chk_st("t1.req24", 0, 1'b0, 1'b0);
      end
      req_none();
      chk_st("t1.req25", 0, 1'b1, 1'b0);
      chk_out_zero("t1.req25");

      // Push and request together into an empty FIFO: no bypass
      step(1'b1, 1'b1, 24'hABCDEF, 1'b0);
      chk_st("lat.push", 1, 1'b1, 1'b0);
      chk_out_zero("lat.push");
      for (int i = 0; i < CELL_LEN; i++) req_exp(24'hABCDEF);
      chk_st("lat.drain", 0, 1'b1, 1'b0);

      // Overflow: fifth push dropped, first four replayed in order
      for (int k = 1; k <= 5; k++) begin
         v = 24'(k) * 24'h010101;
         push(v);
         if (k == 4) chk_st("t2.push4", 4, 1'b1, 1'b0);
         if (k == 5) chk_st("t2.push5", 4, 1'b1, 1'b1);
      end
      for (int k = 1; k <= 4; k++) begin
         v = 24'(k) * 24'h010101;
         for (int i = 0; i < CELL_LEN; i++) req_exp(v);
      end
      chk_st("t2.drain", 0, 1'b1, 1'b1);

      // Reset to clear the sticky flags
      resetn = 1'b0;
      #1;
      chk_st("rst1", 0, 1'b0, 1'b0);
      @(posedge clkn);
      resetn = 1'b1;

      // Full FIFO with concurrent pop accepts the push
      push(24'h111111);
      push(24'h222222);
      push(24'h333333);
      push(24'h444444);
      chk_st("t3.full", 4, 1'b0, 1'b0);
      for (int i = 0; i < CELL_LEN - 1; i++) req_exp(24'h111111);
      exp_q.push_back(24'h111111);
      step(1'b1, 1'b1, 24'hAABBCC, 1'b0);
      chk_st("t3.concurrent", 4, 1'b0, 1'b0);
      for (int i = 0; i < CELL_LEN; i++) req_exp(24'h222222);
      for (int i = 0; i < CELL_LEN; i++) req_exp(24'h333333);
      for (int i = 0; i < CELL_LEN; i++) req_exp(24'h444444);
      for (int i = 0; i < CELL_LEN; i++) req_exp(24'hAABBCC);
      chk_st("t3.drain", 0, 1'b0, 1'b0);

      // Gapped requests: the cell still lasts exactly CELL_LEN requests
      push(24'h00FF00);
      for (int i = 0; i < 2 * CELL_LEN; i++) begin
         if (i % 2 == 0) req_exp(24'h00FF00);
         else step(1'b0, 1'b0, 24'h0, 1'b0);
         if (i == 2 * CELL_LEN - 3) chk_st("t4.req23", 1, 1'b0, 1'b0);
         if (i == 2 * CELL_LEN - 2) chk_st("t4.req24", 0, 1'b0, 1'b0);
      end
      chk_st("t4.end", 0, 1'b0, 1'b0);

      // Flush mid-cell with a same-cycle push
      push(24'h0A0A0A);
      push(24'h0B0B0B);
      push(24'h0C0C0C);
      for (int i = 0; i < 10; i++) req_exp(24'h0A0A0A);
      chk_st("t5.pre", 3, 1'b0, 1'b0);
      step(1'b1, 1'b1, 24'h777777, 1'b1);
      chk_st("t5.sof", 1, 1'b0, 1'b0);
      chk_out_zero("t5.sof");
      for (int i = 0; i < CELL_LEN; i++) begin
         req_exp(24'h777777);
         if (i == CELL_LEN - 2) chk_st("t5.req23", 1, 1'b0, 1'b0);
      end
      chk_st("t5.drain", 0, 1'b0, 1'b0);
      req_none();
      chk_st("t5.uf", 0, 1'b1, 1'b0);

      // Asynchronous reset mid-stream
      push(24'h0D0D0D);
      push(24'h0E0E0E);
      for (int i = 0; i < 5; i++) req_exp(24'h0D0D0D);
      chk_st("t6.pre", 2, 1'b1, 1'b0);
      #2 resetn = 1'b0;
      #1;
      chk_out_zero("t6.reset");
      chk_st("t6.reset", 0, 1'b0, 1'b0);
      @(posedge clkn);
      resetn = 1'b1;
      req_none();
      chk_st("t6.req", 0, 1'b1, 1'b0);
      chk_out_zero("t6.req");
      push(24'h5A5A5A);
      chk_st("t6.push", 1, 1'b1, 1'b0);
      for (int i = 0; i < CELL_LEN; i++) req_exp(24'h5A5A5A);
      chk_st("t6.drain", 0, 1'b1, 1'b0);

      step(1'b0, 1'b0, 24'h0, 1'b0);
      chk("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
